// File: rtl/signnarrow_stream.sv
// Streaming sign-narrowing stage with a 2-entry skid buffer and a saturating overflow counter.
// Define SIGNNARROW_SAT_EN to saturate out-of-range words instead of truncating them.
module signnarrow_stream #(
  parameter int IN    = 10,
  parameter int OUT   = 5,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic [IN-1:0]    d_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [OUT-1:0]   d_o,
  output logic             ovf_o,
  input  logic             ready_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] ovf_count_o
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t           r_state, w_state_next;
  logic [OUT-1:0]   r_main_d, r_skid_d;
  logic             r_main_ovf, r_skid_ovf;
  logic [CNT_W-1:0] r_count;

  logic [IN-OUT:0]  w_top;
  logic             w_ovf;
  logic [OUT-1:0]   w_narrow;
  logic             w_accept, w_pop;
  logic             w_load_main, w_main_from_skid, w_load_skid;

  // The word fits when every bit from the new sign position upward matches.
  assign w_top = d_i[IN-1:OUT-1];
  assign w_ovf = ~((&w_top) | ~(|w_top));

`ifdef SIGNNARROW_SAT_EN
  always_comb begin
    w_narrow = d_i[OUT-1:0];
    if (w_ovf)
      w_narrow = d_i[IN-1] ? {1'b1, {(OUT-1){1'b0}}} : {1'b0, {(OUT-1){1'b1}}};
  end
`else
  assign w_narrow = d_i[OUT-1:0];
`endif

  // ready_o is a function of state and reset only, so backpressure is registered.
  assign ready_o  = ~reset & (r_state != S_TWO);
  assign valid_o  = (r_state != S_EMPTY);
  assign w_accept = valid_i & ready_o;
  assign w_pop    = valid_o & ready_i;

  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_load_main  = 1'b1;
          w_state_next = S_ONE;
        end
      end
      S_ONE: begin
        if (w_accept && w_pop) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_load_skid  = 1'b1;
          w_state_next = S_TWO;
        end else if (w_pop) begin
          w_state_next = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_main_from_skid = 1'b1;
          w_state_next     = S_ONE;
        end
      end
      default: w_state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_EMPTY;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_main_d   <= '0;
      r_main_ovf <= 1'b0;
      r_skid_d   <= '0;
      r_skid_ovf <= 1'b0;
    end else begin
      if (w_load_main) begin
        r_main_d   <= w_narrow;
        r_main_ovf <= w_ovf;
      end else if (w_main_from_skid) begin
        r_main_d   <= r_skid_d;
        r_main_ovf <= r_skid_ovf;
      end
      if (w_load_skid) begin
        r_skid_d   <= w_narrow;
        r_skid_ovf <= w_ovf;
      end
    end
  end

  // Counts at accept time, so it is independent of when the word drains.
  always_ff @(posedge clk) begin
    if (reset || clear_i)
      r_count <= '0;
    else if (w_accept && w_ovf && (r_count != {CNT_W{1'b1}}))
      r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign d_o         = r_main_d;
  assign ovf_o       = r_main_ovf;
  assign ovf_count_o = r_count;

endmodule

// File: tb/tb_signnarrow_stream.sv
// Self-checking bench: directed scenarios with literal expectations plus a randomized run
// checked every cycle against a queue-based reference model.
module tb_signnarrow_stream;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_i, ready_i, clear_i;
  logic [9:0] d_i;
  logic       ready_o, valid_o, ovf_o;
  logic [4:0] d_o;
  logic [7:0] ovf_count_o;
  logic       ready2_o, valid2_o, ovf2_o;
  logic [4:0] d2_o;
  logic [1:0] ovf_count2_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0] d;
    bit         ovf;
  } word_t;

  word_t m_q[$];
  int    m_cnt8 = 0;
  int    m_cnt2 = 0;

  always #5 clk = ~clk;

  signnarrow_stream #(.IN(10), .OUT(5), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .valid_i(valid_i), .d_i(d_i), .ready_o(ready_o),
    .valid_o(valid_o), .d_o(d_o), .ovf_o(ovf_o), .ready_i(ready_i),
    .clear_i(clear_i), .ovf_count_o(ovf_count_o));

  signnarrow_stream #(.IN(10), .OUT(5), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .valid_i(valid_i), .d_i(d_i), .ready_o(ready2_o),
    .valid_o(valid2_o), .d_o(d2_o), .ovf_o(ovf2_o), .ready_i(ready_i),
    .clear_i(clear_i), .ovf_count_o(ovf_count2_o));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference narrowing from the numeric value of the source word.
  function automatic word_t model_narrow(input logic [9:0] d);
    word_t w;
    int v;
    int o;
    v = int'($signed(d));
    w.ovf = (v > 15) || (v < -16);
    o = v;
`ifdef SIGNNARROW_SAT_EN
    if (v > 15) o = 15;
    else if (v < -16) o = -16;
`endif
    w.d = o[4:0];
    return w;
  endfunction

  // Per-cycle compare and model update; inputs are stable between negedge and posedge.
  always @(negedge clk) begin
    bit exp_valid, exp_ready, acc, pop;
    word_t nw;
    exp_valid = (m_q.size() > 0);
    exp_ready = !reset && (m_q.size() < 2);
    chk("ready_o", int'(ready_o), int'(exp_ready));
    chk("valid_o", int'(valid_o), int'(exp_valid));
    chk("ready2_o", int'(ready2_o), int'(exp_ready));
    chk("valid2_o", int'(valid2_o), int'(exp_valid));
    if (exp_valid) begin
      chk("d_o", int'(d_o), int'(m_q[0].d));
      chk("ovf_o", int'(ovf_o), int'(m_q[0].ovf));
      chk("d2_o", int'(d2_o), int'(m_q[0].d));
      chk("ovf2_o", int'(ovf2_o), int'(m_q[0].ovf));
    end
    chk("count8", int'(ovf_count_o), m_cnt8);
    chk("count2", int'(ovf_count2_o), m_cnt2);
    if (reset) begin
      m_q.delete();
      m_cnt8 = 0;
      m_cnt2 = 0;
    end else begin
      acc = valid_i && exp_ready;
      pop = exp_valid && ready_i;
      nw  = model_narrow(d_i);
      if (pop) void'(m_q.pop_front());
      if (acc) m_q.push_back(nw);
      if (clear_i) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end else if (acc && nw.ovf) begin
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp2;
    reset = 1'b1; valid_i = 1'b0; ready_i = 1'b0; clear_i = 1'b0; d_i = '0;
    step(); step();
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_ready", int'(ready_o), 0);
    chk("rst_d", int'(d_o), 0);
    chk("rst_ovf", int'(ovf_o), 0);
    chk("rst_cnt", int'(ovf_count_o), 0);
    reset = 1'b0; #1;
    chk("post_rst_ready", int'(ready_o), 1);

    // Range edges and overflow
    ready_i = 1'b1; valid_i = 1'b1;
    d_i = 10'h00F; step();
    chk("edge_pos_d", int'(d_o), 'h0F); chk("edge_pos_ovf", int'(ovf_o), 0);
    chk("edge_pos_valid", int'(valid_o), 1);
    d_i = 10'h3F0; step();
    chk("edge_neg_d", int'(d_o), 'h10); chk("edge_neg_ovf", int'(ovf_o), 0);
    d_i = 10'h010; step();
`ifdef SIGNNARROW_SAT_EN
    exp2 = 'h0F;
`else
    exp2 = 'h10;
`endif
    chk("ovf_pos_d", int'(d_o), exp2); chk("ovf_pos_ovf", int'(ovf_o), 1);
    d_i = 10'h3EF; step();
`ifdef SIGNNARROW_SAT_EN
    exp2 = 'h10;
`else
    exp2 = 'h0F;
`endif
    chk("ovf_neg_d", int'(d_o), exp2); chk("ovf_neg_ovf", int'(ovf_o), 1);
    valid_i = 1'b0; step();
    chk("drain_valid", int'(valid_o), 0);
    chk("ovf_cnt_2", int'(ovf_count_o), 2);

    // Backpressure
    ready_i = 1'b0; valid_i = 1'b1;
    d_i = 10'h001; step(); chk("bp_ready1", int'(ready_o), 1);
    d_i = 10'h002; step(); chk("bp_ready2", int'(ready_o), 0);
    d_i = 10'h003; step(); chk("bp_hold_ready", int'(ready_o), 0);
    chk("bp_head", int'(d_o), 1);
    ready_i = 1'b1; step(); chk("bp_out2", int'(d_o), 2);
    step(); chk("bp_out3", int'(d_o), 3); chk("bp_out3_valid", int'(valid_o), 1);
    valid_i = 1'b0; step(); chk("bp_empty", int'(valid_o), 0);

    // Saturating counter on the 2-bit instance
    clear_i = 1'b1; step(); clear_i = 1'b0;
    valid_i = 1'b1; d_i = 10'h100;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("cnt2_sat", int'(ovf_count2_o), (i < 3) ? i + 1 : 3);
    end
    clear_i = 1'b1; step();
    chk("cnt2_clear", int'(ovf_count2_o), 0);
    chk("cnt8_clear", int'(ovf_count_o), 0);
    clear_i = 1'b0; valid_i = 1'b0; step();

    // Reset while two words are buffered
    ready_i = 1'b0; valid_i = 1'b1;
    d_i = 10'h005; step();
    d_i = 10'h006; step();
    chk("mid_two_ready", int'(ready_o), 0);
    valid_i = 1'b0; reset = 1'b1; ready_i = 1'b1; #1;
    chk("mid_rst_ready", int'(ready_o), 0);
    step();
    chk("mid_rst_valid", int'(valid_o), 0);
    chk("mid_rst_cnt", int'(ovf_count_o), 0);
    chk("mid_rst_ready_hold", int'(ready_o), 0);
    reset = 1'b0; valid_i = 1'b1; d_i = 10'h007; step();
    chk("mid_next_d", int'(d_o), 7); chk("mid_next_valid", int'(valid_o), 1);
    valid_i = 1'b0; step();
    chk("mid_no_stale", int'(valid_o), 0);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      reset   = ($urandom_range(0, 499) == 0);
      clear_i = ($urandom_range(0, 63) == 0);
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 2))
        0: d_i = 10'($urandom);
        1: d_i = 10'($urandom_range(14, 17));
        default: d_i = 10'(1008 + $urandom_range(0, 5));
      endcase
      step();
    end
    reset = 1'b0; clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    step(); step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
